data_mem_responder: RTL and testbench

- Word-addressed data memory that acts as the responder side of the processor's load/store interface.
- Accepts one request at a time over a valid/ready handshake and inserts a configurable number of wait states.
- Returns read data or a write acknowledgement over a second valid/ready handshake.
- Sits between the processor datapath's data port and the system; allows stall-capable (multi-cycle) datapaths to be exercised.

---
 rtl/data_mem_responder_if.sv | 56 +++++
 rtl/data_mem_responder.sv | 212 +++++++++++++++++++++
 tb/tb_data_mem_responder.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_responder_if.sv
// -----------------------------------------------------------------------------
// data_mem_responder_if
//   Load/store bus between a processor data port (master) and the data memory
//   responder (slave). Two valid/ready handshakes: request and response.
//
//   Signals:
//     req_valid   master -> slave  request present
//     req_ready   slave  -> master responder can accept a request
//     req_write   master -> slave  1 = store, 0 = load
//     req_addr    master -> slave  byte address
//     req_wdata   master -> slave  store data
//     resp_valid  slave  -> master response present
//     resp_ready  master -> slave  requester accepts the response
//     resp_rdata  slave  -> master load data / stored-word echo
//     resp_err    slave  -> master access error
// -----------------------------------------------------------------------------
interface data_mem_responder_if #(
  parameter int unsigned WORD_SIZE  = 32,
  parameter int unsigned ADDR_WIDTH = 8
) ();

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [WORD_SIZE-1:0]  req_wdata;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [WORD_SIZE-1:0]  resp_rdata;
  logic                  resp_err;

  modport master (
    output req_valid,
    output req_write,
    output req_addr,
    output req_wdata,
    output resp_ready,
    input  req_ready,
    input  resp_valid,
    input  resp_rdata,
    input  resp_err
  );

  modport slave (
    input  req_valid,
    input  req_write,
    input  req_addr,
    input  req_wdata,
    input  resp_ready,
    output req_ready,
    output resp_valid,
    output resp_rdata,
    output resp_err
  );

endinterface

// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
//   Word-addressed data memory acting as the responder on the processor
//   load/store bus. One request at a time, WAIT_CYCLES wait states between
//   acceptance and response, then a held response until the requester takes it.
//   The access commits on the edge that enters the response state, so a load
//   following a store to the same word always sees the new data.
//
//   Optional build macro: DMEM_ALIGN_CHECK_EN
//     defined   : requests with req_addr[1:0] != 0 do not touch storage, return
//                 resp_rdata = 0 and resp_err = 1 (still counted as completed)
//     undefined : req_addr[1:0] ignored, resp_err tied to 0
//
//   Ports:
//     i_clk        clock, rising edge
//     i_rst_n      asynchronous active-low reset (clears storage too)
//     bus          slave side of data_mem_responder_if (request/response)
//     o_busy       transaction in flight (WAIT or RESP)
//     o_txn_count  completed-transaction counter, wraps at 16 bits
// -----------------------------------------------------------------------------
module data_mem_responder #(
  parameter int unsigned WORD_SIZE   = 32,
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  data_mem_responder_if.slave       bus,
  output logic                      o_busy,
  output logic [15:0]               o_txn_count
);

  localparam int unsigned IdxW  = ADDR_WIDTH - 2;
  localparam int unsigned Depth = 2 ** IdxW;
  // Counter preload so that exactly WAIT_CYCLES cycles are spent in StWait.
  localparam logic [3:0]  WaitInit = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } state_e;

  state_e                 r_state;
  state_e                 w_state_next;
  logic [3:0]             r_wait_cnt;
  logic [3:0]             w_wait_cnt_next;

  logic                   r_write;
  logic [IdxW-1:0]        r_idx;
  logic [WORD_SIZE-1:0]   r_wdata;
  logic [WORD_SIZE-1:0]   r_mem [Depth];
  logic [WORD_SIZE-1:0]   r_rdata;
  logic [15:0]            r_txn_count;

  logic                   w_accept;
  logic                   w_resp_hs;
  logic                   w_commit;
  logic                   w_op_write;
  logic [IdxW-1:0]        w_op_idx;
  logic [WORD_SIZE-1:0]   w_op_wdata;
  logic                   w_op_misalign;
  logic                   w_do_store;
  logic [WORD_SIZE-1:0]   w_commit_rdata;

  assign w_accept  = (r_state == StIdle) && bus.req_valid;
  assign w_resp_hs = (r_state == StResp) && bus.resp_ready;
  // Entering StResp is the commit point, whether from StWait or (zero wait
  // states) straight from StIdle.
  assign w_commit  = (w_state_next == StResp) && (r_state != StResp);

  // With zero wait states the commit happens on the accept edge itself, so the
  // operation comes straight from the bus rather than from the capture regs.
  assign w_op_write = (r_state == StIdle) ? bus.req_write : r_write;
  assign w_op_idx   = (r_state == StIdle) ? bus.req_addr[ADDR_WIDTH-1:2] : r_idx;
  assign w_op_wdata = (r_state == StIdle) ? bus.req_wdata : r_wdata;

`ifdef DMEM_ALIGN_CHECK_EN
  logic r_misalign;
  logic r_err;

  assign w_op_misalign = (r_state == StIdle) ? (bus.req_addr[1:0] != 2'b00) : r_misalign;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_misalign <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      if (w_accept) begin
        r_misalign <= (bus.req_addr[1:0] != 2'b00);
      end
      if (w_commit) begin
        r_err <= w_op_misalign;
      end
    end
  end

  assign bus.resp_err = r_err && (r_state == StResp);
`else
  logic w_unused_addr_lsb;

  assign w_unused_addr_lsb = ^bus.req_addr[1:0];
  assign w_op_misalign     = 1'b0;
  assign bus.resp_err      = 1'b0;
`endif

  assign w_do_store = w_commit && w_op_write && !w_op_misalign;

  always_comb begin
    w_commit_rdata = '0;
    if (!w_op_misalign) begin
      w_commit_rdata = w_op_write ? w_op_wdata : r_mem[w_op_idx];
    end
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= StIdle;
      r_wait_cnt <= 4'd0;
    end else begin
      r_state    <= w_state_next;
      r_wait_cnt <= w_wait_cnt_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_wait_cnt_next = r_wait_cnt;
    unique case (r_state)
      StIdle: begin
        if (bus.req_valid) begin
          if (WAIT_CYCLES == 0) begin
            w_state_next = StResp;
          end else begin
            w_state_next    = StWait;
            w_wait_cnt_next = WaitInit;
          end
        end
      end
      StWait: begin
        if (r_wait_cnt == 4'd0) begin
          w_state_next = StResp;
        end else begin
          w_wait_cnt_next = r_wait_cnt - 4'd1;
        end
      end
      StResp: begin
        if (bus.resp_ready) begin
          w_state_next = StIdle;
        end
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Request capture
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_write <= 1'b0;
      r_idx   <= '0;
      r_wdata <= '0;
    end else if (w_accept) begin
      r_write <= bus.req_write;
      r_idx   <= bus.req_addr[ADDR_WIDTH-1:2];
      r_wdata <= bus.req_wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Storage: cleared by reset, so a reset during WAIT leaves nothing behind.
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < int'(Depth); i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_do_store) begin
      r_mem[w_op_idx] <= w_op_wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Response data and completion counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rdata     <= '0;
      r_txn_count <= 16'd0;
    end else begin
      if (w_commit) begin
        r_rdata <= w_commit_rdata;
      end
      if (w_resp_hs) begin
        r_txn_count <= r_txn_count + 16'd1;
      end
    end
  end

  assign bus.req_ready  = (r_state == StIdle);
  assign bus.resp_valid = (r_state == StResp);
  assign bus.resp_rdata = r_rdata;
  assign o_busy         = (r_state != StIdle);
  assign o_txn_count    = r_txn_count;

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

  localparam int unsigned WordSize   = 32;
  localparam int unsigned AddrWidth  = 8;
  localparam int unsigned WaitCycles = 2;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        busy;
  logic [15:0] txn_count;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_resp   = 0;

  always #5 clk = ~clk;

  data_mem_responder_if #(
    .WORD_SIZE (WordSize),
    .ADDR_WIDTH(AddrWidth)
  ) bus_if ();

  data_mem_responder #(
    .WORD_SIZE  (WordSize),
    .ADDR_WIDTH (AddrWidth),
    .WAIT_CYCLES(WaitCycles)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .bus        (bus_if.slave),
    .o_busy     (busy),
    .o_txn_count(txn_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  // Scoreboard monitor: every response handshake pops one expected entry.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus_if.resp_valid && bus_if.resp_ready) begin
      n_resp++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_resp: got rdata 0x%08h, expected no response",
                 bus_if.resp_rdata);
      end else begin
        e = exp_q.pop_front();
        check("resp_rdata", bus_if.resp_rdata, e.rdata);
        check("resp_err", {31'd0, bus_if.resp_err}, {31'd0, e.err});
      end
    end
  end

  // Drive a request and return just after the edge that accepted it.
  task automatic send(input logic wr, input logic [7:0] addr, input logic [31:0] wd);
    bit accepted = 1'b0;
    bus_if.req_write = wr;
    bus_if.req_addr  = addr;
    bus_if.req_wdata = wd;
    bus_if.req_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus_if.req_ready) begin
        accepted = 1'b1;
        break;
      end
    end
    if (!accepted) begin
      n_checks++;
      n_errors++;
      $display("FAIL accept_timeout: got req_ready 0, expected 1 within 40 cycles");
    end
    @(posedge clk);
    #1;
    bus_if.req_valid = 1'b0;
  endtask

  // Negedges after the accept edge until resp_valid is seen (0 = never).
  task automatic get_lat(output int lat);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (bus_if.resp_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic wait_resp(input int target);
    bit done = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      if (n_resp >= target) begin
        done = 1'b1;
        break;
      end
    end
    #1;
    if (!done) begin
      n_checks++;
      n_errors++;
      $display("FAIL resp_timeout: got %0d responses, expected %0d", n_resp, target);
    end
  endtask

  task automatic txn(input logic wr, input logic [7:0] addr, input logic [31:0] wd,
                     input logic [31:0] exp_rdata, input logic exp_err, output int lat);
    int target;
    exp_q.push_back('{rdata: exp_rdata, err: exp_err});
    target = n_resp + 1;
    send(wr, addr, wd);
    get_lat(lat);
    wait_resp(target);
  endtask

  task automatic apply_reset(input int cycles);
    rst_n = 1'b0;
    #1;
    check("rst_resp_valid", {31'd0, bus_if.resp_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    repeat (cycles) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_req_ready", {31'd0, bus_if.req_ready}, 32'd1);
    check("rst_txn_count", {16'd0, txn_count}, 32'd0);
    check("rst_resp_rdata", bus_if.resp_rdata, 32'd0);
    check("rst_resp_err", {31'd0, bus_if.resp_err}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000 time units");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   lat;
    int   target;
    logic exp_mis_err;
    logic [31:0] exp_mis_rdata;
    logic [31:0] exp_after_mis;

`ifdef DMEM_ALIGN_CHECK_EN
    exp_mis_err   = 1'b1;
    exp_mis_rdata = 32'h0000_0000;
    exp_after_mis = 32'hDEAD_BEEF;
`else
    exp_mis_err   = 1'b0;
    exp_mis_rdata = 32'hAAAA_5555;
    exp_after_mis = 32'hAAAA_5555;
`endif

    bus_if.req_valid  = 1'b0;
    bus_if.req_write  = 1'b0;
    bus_if.req_addr   = 8'h00;
    bus_if.req_wdata  = 32'h0;
    bus_if.resp_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("init_req_ready", {31'd0, bus_if.req_ready}, 32'd1);
    check("init_txn_count", {16'd0, txn_count}, 32'd0);
    @(posedge clk);
    #1;

    // Reset mid-simulation wipes a previously stored word.
    txn(1'b1, 8'h10, 32'h0000_1111, 32'h0000_1111, 1'b0, lat);
    check("txn_before_reset", {16'd0, txn_count}, 32'd1);
    @(posedge clk);
    #1;
    apply_reset(2);
    @(posedge clk);
    #1;
    txn(1'b0, 8'h10, 32'h0, 32'h0000_0000, 1'b0, lat);

    // Store/load with latency: resp_valid in the third cycle after acceptance.
    txn(1'b1, 8'h08, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, lat);
    check("store_latency", 32'(lat), 32'(WaitCycles + 1));
    txn(1'b0, 8'h08, 32'h0, 32'hDEAD_BEEF, 1'b0, lat);
    check("load_latency", 32'(lat), 32'(WaitCycles + 1));
    check("txn_after_store_load", {16'd0, txn_count}, 32'd3);

    // Backpressure: response held; a request pulse meanwhile is ignored.
    bus_if.resp_ready = 1'b0;
    exp_q.push_back('{rdata: 32'hDEAD_BEEF, err: 1'b0});
    target = n_resp + 1;
    send(1'b0, 8'h08, 32'h0);
    get_lat(lat);
    check("bp_latency", 32'(lat), 32'(WaitCycles + 1));
    bus_if.req_write = 1'b1;
    bus_if.req_addr  = 8'h0C;
    bus_if.req_wdata = 32'h5555_AAAA;
    bus_if.req_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_resp_valid", {31'd0, bus_if.resp_valid}, 32'd1);
      check("bp_resp_rdata", bus_if.resp_rdata, 32'hDEAD_BEEF);
      check("bp_req_ready", {31'd0, bus_if.req_ready}, 32'd0);
    end
    check("bp_txn_count", {16'd0, txn_count}, 32'd3);
    @(posedge clk);
    #1;
    bus_if.req_valid  = 1'b0;
    bus_if.resp_ready = 1'b1;
    wait_resp(target);
    @(negedge clk);
    check("bp_resp_valid_drop", {31'd0, bus_if.resp_valid}, 32'd0);
    check("bp_txn_after", {16'd0, txn_count}, 32'd4);
    check("bp_rdata_retained", bus_if.resp_rdata, 32'hDEAD_BEEF);
    @(posedge clk);
    #1;
    txn(1'b0, 8'h0C, 32'h0, 32'h0000_0000, 1'b0, lat);

    // Boundary address.
    txn(1'b1, 8'hFC, 32'h1234_5678, 32'h1234_5678, 1'b0, lat);
    txn(1'b0, 8'hFC, 32'h0, 32'h1234_5678, 1'b0, lat);
    txn(1'b0, 8'h00, 32'h0, 32'h0000_0000, 1'b0, lat);

    // Misaligned store.
    txn(1'b1, 8'h09, 32'hAAAA_5555, exp_mis_rdata, exp_mis_err, lat);
    txn(1'b0, 8'h08, 32'h0, exp_after_mis, 1'b0, lat);
    check("txn_after_misalign", {16'd0, txn_count}, 32'd10);

    // Reset during WAIT discards the pending store.
    send(1'b1, 8'h04, 32'hCAFE_F00D);
    check("mid_busy", {31'd0, busy}, 32'd1);
    check("mid_resp_valid", {31'd0, bus_if.resp_valid}, 32'd0);
    apply_reset(2);
    repeat (4) begin
      @(negedge clk);
      check("post_rst_no_resp", {31'd0, bus_if.resp_valid}, 32'd0);
    end
    @(posedge clk);
    #1;
    txn(1'b0, 8'h04, 32'h0, 32'h0000_0000, 1'b0, lat);
    txn(1'b0, 8'h08, 32'h0, 32'h0000_0000, 1'b0, lat);
    check("final_txn_count", {16'd0, txn_count}, 32'd2);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
